// File: rtl/scaled_fb_reader.sv
// rtl/scaled_fb_reader.sv - DDA-scaled framebuffer scan-out with latency-matched VGA timing
//
// Walks a SRC_W x SRC_H BRAM image and stretches it over a DST_W x DST_H
// visible area using exact fractional accumulators in both axes.
// Ports:
//   CLK, RESET                   pixel clock, synchronous active-high reset
//   ENABLE                       scan-out enable (low restarts the frame, blanks colour)
//   MODE                         0 grey, 1 RGB332, 2 test pattern, 3 inverted grey
//   VGA_HS_IN/VS_IN/VISIBLE_IN   raw timing from the VGA controller
//   BRAM_ADDR / BRAM_DOUT        registered read address / read data (RD_LAT later)
//   VGA_R/G/B                    registered colour
//   VGA_HS/VS/VISIBLE            timing delayed by RD_LAT+2 to line up with colour
module scaled_fb_reader #(
    parameter int   SRC_W    = 576,
    parameter int   SRC_H    = 378,
    parameter int   DST_W    = 800,
    parameter int   DST_H    = 600,
    parameter int   ADDR_W   = 18,
    parameter int   RD_LAT   = 1,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic [1:0]        MODE,
    input  logic              VGA_HS_IN,
    input  logic              VGA_VS_IN,
    input  logic              VGA_VISIBLE_IN,
    output logic [ADDR_W-1:0] BRAM_ADDR,
    input  logic [7:0]        BRAM_DOUT,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_VISIBLE
);
    localparam int LAT    = RD_LAT + 2;
    localparam int SX_W   = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int XACC_W = $clog2(DST_W) + 1;
    localparam int YACC_W = $clog2(DST_H) + 1;
    localparam int DX_W   = $clog2(DST_W + 1);
    localparam int DY_W   = $clog2(DST_H + 1);

    typedef struct packed {
        logic       blank;
        logic [7:0] test_r;
        logic [7:0] test_g;
    } tag_t;

    logic [SX_W-1:0]   sx;
    logic [XACC_W-1:0] xacc;
    logic [ADDR_W-1:0] line_base;
    logic [YACC_W-1:0] yacc;
    logic [DX_W-1:0]   dx;
    logic [DY_W-1:0]   dy;
    logic              prev_visible;

    logic              restart;
    logic              in_area;
    logic              issue;
    logic [XACC_W-1:0] xacc_sum;
    logic [YACC_W-1:0] yacc_sum;

    tag_t              tag_d [RD_LAT+1];
    logic [LAT-1:0]    hs_d;
    logic [LAT-1:0]    vs_d;
    logic [LAT-1:0]    vis_d;
    logic [7:0]        r_next, g_next, b_next;
    logic [7:0]        d;

    assign restart  = RESET || !ENABLE || (VGA_VS_IN == SYNC_POL);
    assign in_area  = (dx < DX_W'(DST_W)) && (dy < DY_W'(DST_H));
    assign issue    = !restart && VGA_VISIBLE_IN && in_area;
    assign xacc_sum = xacc + XACC_W'(SRC_W);
    assign yacc_sum = yacc + YACC_W'(SRC_H);

    // Scan position. The accumulators hold the fractional remainder of
    // x*SRC_W/DST_W (resp. y*SRC_H/DST_H); since SRC <= DST the integer part
    // advances by at most one per step.
    always_ff @(posedge CLK) begin
        prev_visible <= RESET ? 1'b0 : VGA_VISIBLE_IN;
        if (restart) begin
            sx        <= '0;
            xacc      <= '0;
            line_base <= '0;
            yacc      <= '0;
            dx        <= '0;
            dy        <= '0;
        end else if (VGA_VISIBLE_IN) begin
            // Stepping stops once the pixel leaves the area; dx then rests at DST_W.
            if (in_area) begin
                if (xacc_sum >= XACC_W'(DST_W)) begin
                    sx   <= sx + SX_W'(1);
                    xacc <= xacc_sum - XACC_W'(DST_W);
                end else begin
                    xacc <= xacc_sum;
                end
                dx <= dx + DX_W'(1);
            end
        end else if (prev_visible) begin
            sx   <= '0;
            xacc <= '0;
            dx   <= '0;
            if (dy < DY_W'(DST_H)) begin
                if (yacc_sum >= YACC_W'(DST_H)) begin
                    line_base <= line_base + ADDR_W'(SRC_W);
                    yacc      <= yacc_sum - YACC_W'(DST_H);
                end else begin
                    yacc <= yacc_sum;
                end
                dy <= dy + DY_W'(1);
            end
        end
    end

    // Address issue plus a per-pixel tag that rides alongside the BRAM read
    // so the colour stage sees blanking and test values for the same pixel.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            BRAM_ADDR <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_d[i] <= '{blank: 1'b1, test_r: 8'd0, test_g: 8'd0};
            end
        end else begin
            if (issue) begin
                BRAM_ADDR <= line_base + ADDR_W'(sx);
            end
            tag_d[0] <= '{blank: !issue, test_r: 8'(sx), test_g: 8'(dy)};
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_d[i] <= tag_d[i-1];
            end
        end
    end

    assign d = BRAM_DOUT;

    // ENABLE and MODE are taken at the colour stage, so a pixel already in
    // flight is blanked by ENABLE low and a MODE change applies immediately.
    always_comb begin
        r_next = 8'd0;
        g_next = 8'd0;
        b_next = 8'd0;
        if (ENABLE && !tag_d[RD_LAT].blank) begin
            case (MODE)
                2'd0: begin
                    r_next = d;
                    g_next = d;
                    b_next = d;
                end
                2'd1: begin
                    r_next = {d[7:5], d[7:5], d[7:6]};
                    g_next = {d[4:2], d[4:2], d[4:3]};
                    b_next = {d[1:0], d[1:0], d[1:0], d[1:0]};
                end
                2'd2: begin
                    r_next = tag_d[RD_LAT].test_r;
                    g_next = tag_d[RD_LAT].test_g;
                    b_next = 8'h80;
                end
                default: begin
                    r_next = ~d;
                    g_next = ~d;
                    b_next = ~d;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            VGA_R <= 8'd0;
            VGA_G <= 8'd0;
            VGA_B <= 8'd0;
            hs_d  <= {LAT{~SYNC_POL}};
            vs_d  <= {LAT{~SYNC_POL}};
            vis_d <= '0;
        end else begin
            VGA_R <= r_next;
            VGA_G <= g_next;
            VGA_B <= b_next;
            hs_d  <= {hs_d[LAT-2:0], VGA_HS_IN};
            vs_d  <= {vs_d[LAT-2:0], VGA_VS_IN};
            vis_d <= {vis_d[LAT-2:0], VGA_VISIBLE_IN};
        end
    end

    assign VGA_HS      = hs_d[LAT-1];
    assign VGA_VS      = vs_d[LAT-1];
    assign VGA_VISIBLE = vis_d[LAT-1];
endmodule

// File: tb/tb_scaled_fb_reader.sv
// tb/tb_scaled_fb_reader.sv - scoreboard bench for scaled_fb_reader with a floor-division reference model
module tb_scaled_fb_reader;
    localparam int   SRC_W    = 3;
    localparam int   SRC_H    = 2;
    localparam int   DST_W    = 5;
    localparam int   DST_H    = 4;
    localparam int   ADDR_W   = 4;
    localparam int   RD_LAT   = 1;
    localparam logic SYNC_POL = 1'b1;
    localparam int   HMAX     = 16384;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              ENABLE = 1'b0;
    logic [1:0]        MODE = 2'd0;
    logic              VGA_HS_IN = 1'b0;
    logic              VGA_VS_IN = 1'b0;
    logic              VGA_VISIBLE_IN = 1'b0;
    logic [ADDR_W-1:0] BRAM_ADDR;
    logic [7:0]        BRAM_DOUT = 8'd0;
    logic [7:0]        VGA_R, VGA_G, VGA_B;
    logic              VGA_HS, VGA_VS, VGA_VISIBLE;

    scaled_fb_reader #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .DST_W(DST_W), .DST_H(DST_H),
        .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .SYNC_POL(SYNC_POL)
    ) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .MODE(MODE),
        .VGA_HS_IN(VGA_HS_IN), .VGA_VS_IN(VGA_VS_IN), .VGA_VISIBLE_IN(VGA_VISIBLE_IN),
        .BRAM_ADDR(BRAM_ADDR), .BRAM_DOUT(BRAM_DOUT),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_VISIBLE(VGA_VISIBLE)
    );

    always #5 CLK = ~CLK;

    logic [7:0] mem [16];
    always @(posedge CLK) BRAM_DOUT <= mem[BRAM_ADDR];

    typedef struct {
        int         tgt;
        logic       blank;
        logic [3:0] addr;
        logic [7:0] sx;
        logic [7:0] dy;
        logic       hs, vs, vis;
    } pix_t;

    typedef struct {
        int         tgt;
        logic [3:0] addr;
    } addr_t;

    pix_t  pq[$];
    addr_t aq[$];
    logic       rst_h  [HMAX];
    logic       en_h   [HMAX];
    logic [1:0] mode_h [HMAX];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Reference model state: visible column / line counts since the last
    // restart, and the last address issued.
    int         mx = 0;
    int         my = 0;
    logic       mprev = 1'b0;
    logic [3:0] maddr = 4'd0;
    logic [1:0] mode = 2'd0;

    function automatic logic [23:0] exp_rgb(input logic [1:0] m, input logic [7:0] dd,
                                            input logic [7:0] tsx, input logic [7:0] tdy);
        case (m)
            2'd0:    return {dd, dd, dd};
            2'd1:    return {dd[7:5], dd[7:5], dd[7:6], dd[4:2], dd[4:2], dd[4:3],
                             dd[1:0], dd[1:0], dd[1:0], dd[1:0]};
            2'd2:    return {tsx, tdy, 8'h80};
            default: return {~dd, ~dd, ~dd};
        endcase
    endfunction

    task automatic drive(input logic rst, input logic en, input logic [1:0] md,
                         input logic hs, input logic vs, input logic vis);
        pix_t  p;
        addr_t a;
        logic  restart;
        RESET = rst; ENABLE = en; MODE = md;
        VGA_HS_IN = hs; VGA_VS_IN = vs; VGA_VISIBLE_IN = vis;
        rst_h[cyc] = rst; en_h[cyc] = en; mode_h[cyc] = md;
        p.tgt = cyc + RD_LAT + 2; p.blank = 1'b1; p.addr = 4'd0; p.sx = 8'd0; p.dy = 8'd0;
        p.hs = hs; p.vs = vs; p.vis = vis;
        restart = rst || !en || (vs == SYNC_POL);
        if (restart) begin
            mx = 0; my = 0;
            if (rst) maddr = 4'd0;
        end else if (vis) begin
            if (mx < DST_W && my < DST_H) begin
                maddr   = 4'((my * SRC_H / DST_H) * SRC_W + mx * SRC_W / DST_W);
                p.blank = 1'b0;
                p.addr  = maddr;
                p.sx    = 8'(mx * SRC_W / DST_W);
                p.dy    = 8'(my);
                mx++;
            end
        end else if (mprev) begin
            mx = 0;
            if (my < DST_H) my++;
        end
        mprev = rst ? 1'b0 : vis;
        a.tgt = cyc + 1; a.addr = maddr;
        aq.push_back(a);
        pq.push_back(p);
        @(posedge CLK); #1;
        cyc++;
    endtask

    task automatic run_line(input logic en_l, input int len, input logic glitch);
        logic r, v;
        drive(1'b0, en_l, mode, 1'b1, 1'b0, 1'b0);
        drive(1'b0, en_l, mode, 1'b1, 1'b0, 1'b0);
        drive(1'b0, en_l, mode, 1'b0, 1'b0, 1'b0);
        drive(1'b0, en_l, mode, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < len; i++) begin
            r = glitch && ($urandom_range(0, 99) == 0);
            v = glitch && ($urandom_range(0, 59) == 0);
            if (glitch && $urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            drive(r, en_l, mode, 1'b0, v, 1'b1);
        end
    endtask

    // Monitor: pops whatever the scoreboard expects for this cycle.
    always @(negedge CLK) begin : mon
        pix_t        p;
        addr_t       a;
        int          t;
        logic        rst_any;
        logic [26:0] exp_o, got_o;
        if (aq.size() > 0 && aq[0].tgt == cyc) begin
            a = aq.pop_front();
            tests++;
            if (BRAM_ADDR !== a.addr) begin
                fails++;
                $display("FAIL addr cyc=%0d got=%0d expected=%0d", cyc, BRAM_ADDR, a.addr);
            end
        end
        if (pq.size() > 0 && pq[0].tgt == cyc) begin
            p = pq.pop_front();
            t = p.tgt - RD_LAT - 2;
            rst_any = 1'b0;
            for (int k = 0; k < RD_LAT + 2; k++) rst_any |= rst_h[t + k];
            if (rst_any) begin
                exp_o = {1'b0, ~SYNC_POL, ~SYNC_POL, 24'd0};
            end else begin
                exp_o = {p.vis, p.hs, p.vs, 24'd0};
                if (!p.blank && en_h[t + RD_LAT + 1])
                    exp_o[23:0] = exp_rgb(mode_h[t + RD_LAT + 1], mem[p.addr], p.sx, p.dy);
            end
            got_o = {VGA_VISIBLE, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B};
            tests++;
            if (got_o !== exp_o) begin
                fails++;
                $display("FAIL pixel cyc=%0d got vis/hs/vs=%b rgb=%h expected vis/hs/vs=%b rgb=%h",
                         cyc, got_o[26:24], got_o[23:0], exp_o[26:24], exp_o[23:0]);
            end
        end
    end

    initial begin
        int lines, len;
        logic en_l;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        mem[1] = 8'hE3;
        mem[3] = 8'h12;

        repeat (4) drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

        for (int f = 0; f < 40; f++) begin
            repeat (3) drive(1'b0, 1'b1, mode, 1'b0, 1'b1, 1'b0);
            if (f < 4) begin
                mode = 2'(f);
                for (int l = 0; l < DST_H; l++) run_line(1'b1, DST_W, 1'b0);
            end else begin
                lines = DST_H + $urandom_range(0, 2);
                for (int l = 0; l < lines; l++) begin
                    en_l = ($urandom_range(0, 9) != 0);
                    case ($urandom_range(0, 7))
                        0, 1:    len = DST_W + $urandom_range(1, 3);
                        2:       len = $urandom_range(1, DST_W - 1);
                        default: len = DST_W;
                    endcase
                    run_line(en_l, len, 1'b1);
                end
            end
        end

        repeat (RD_LAT + 3) begin
            rst_h[cyc] = RESET; en_h[cyc] = ENABLE; mode_h[cyc] = MODE;
            @(posedge CLK); #1;
            cyc++;
        end

        tests++;
        if (aq.size() != 0 || pq.size() != 0) begin
            fails++;
            $display("FAIL drain got addr_q=%0d pix_q=%0d expected 0/0", aq.size(), pq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/scaled_fb_reader.md
# scaled_fb_reader

Parametrised framebuffer-to-VGA scan-out engine: it walks a SRC_W×SRC_H source image held in BRAM and upscales it to a DST_W×DST_H visible VGA area. It uses exact fractional (DDA) stepping in both axes instead of fixed delta patterns. It sits between the VGA timing controller (sync/visible inputs) and the VGA DAC pins. It re-times sync and visible to match the BRAM read latency and supports several pixel-format and test modes.

## Interface
- SRC_W, 576: source pixels per line; must satisfy 1 ≤ SRC_W ≤ DST_W
- SRC_H, 378: source lines; must satisfy 1 ≤ SRC_H ≤ DST_H
- DST_W, 800: visible VGA pixels per line
- DST_H, 600: visible VGA lines
- ADDR_W, 18: BRAM address width; must satisfy 2^ADDR_W ≥ SRC_W·SRC_H
- RD_LAT, 1: BRAM read latency in cycles (≥1)
- SYNC_POL, 1: active level of VGA_VS_IN
- CLK  in  1  pixel clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- ENABLE  in  1  scan-out enable
- MODE  in  2  0 grey, 1 RGB332, 2 test pattern, 3 inverted grey
- VGA_HS_IN, VGA_VS_IN, VGA_VISIBLE_IN  in  1 each  raw timing from controller
- BRAM_ADDR  out  ADDR_W  registered read address
- BRAM_DOUT  in  8  read data, valid RD_LAT cycles after address
- VGA_R, VGA_G, VGA_B  out  8 each  registered colour
- VGA_HS, VGA_VS, VGA_VISIBLE  out  1 each  inputs delayed by LAT = RD_LAT+2

## Operation
- State registers:
  - SX: source column, clog2(SRC_W) bits
  - XACC: clog2(DST_W)+1 bits
  - LINE_BASE: ADDR_W bits
  - YACC: clog2(DST_H)+1 bits
  - DX, DY: visible pixel and line counters
  - prev_visible
- Frame restart, when VGA_VS_IN == SYNC_POL, or ENABLE = 0, or RESET: SX, XACC, LINE_BASE, YACC, DX and DY all clear to 0. Restart has priority over every other update in the same cycle.
- Visible pixel, a cycle with VGA_VISIBLE_IN = 1:
  - BRAM_ADDR <= LINE_BASE + SX, truncated to ADDR_W.
  - XACC' = XACC + SRC_W. If XACC' ≥ DST_W, then SX += 1 and XACC = XACC' − DST_W; else XACC = XACC'.
  - DX += 1. DX saturates at DST_W.
- Result of the X step: the pixel at visible column x reads source column floor(x·SRC_W/DST_W). SX advances at most once per pixel.
- Line end, the falling edge of VGA_VISIBLE_IN (prev_visible = 1, current = 0):
  - SX, XACC and DX clear.
  - YACC' = YACC + SRC_H. If YACC' ≥ DST_H, then LINE_BASE += SRC_W and YACC = YACC' − DST_H; else YACC = YACC'.
  - DY += 1. DY saturates at DST_H.
- Out-of-area pixels, where DX ≥ DST_W or DY ≥ DST_H:
  - BRAM_ADDR holds its value.
  - A blank flag travels down the pipeline and forces RGB = 0.
- Colour stage, using the BRAM_DOUT aligned to that pixel. A blanked pixel, a non-visible pixel, or ENABLE = 0 outputs 0 on all channels.
  - MODE 0: R = G = B = DOUT.
  - MODE 1: R = {D[7:5],D[7:5],D[7:6]}, G = {D[4:2],D[4:2],D[4:3]}, B = {D[1:0],D[1:0],D[1:0],D[1:0]}.
  - MODE 2: R = SX[7:0] and G = DY[7:0] as registered when the address was issued, B = 8'h80. DOUT is ignored.
  - MODE 3: R = G = B = ~DOUT.
- A MODE change takes effect on the next pixel leaving the colour stage. There is no frame-boundary synchronisation.

## Timing
- Reset values: BRAM_ADDR = 0, RGB = 0, VGA_VISIBLE = 0, all delay-line stages = 0. VGA_HS and VGA_VS reset to ~SYNC_POL (inactive).
- Pixel latency: input pixel in cycle t → BRAM_ADDR at t+1 → BRAM_DOUT at t+1+RD_LAT → RGB at t+2+RD_LAT.
- HS, VS and VISIBLE pass through a LAT-stage shift register, so they stay cycle-aligned with RGB.
- Throughput is one pixel per clock with no stalls.
- Reset or VS asserted mid-line takes effect at the next edge. Pixels already in the pipeline still exit, but blanked if ENABLE = 0.

## Test plan
- SRC_W=3, DST_W=5, SRC_H=2, DST_H=4, RD_LAT=1, one 5-pixel visible line → BRAM_ADDR over consecutive cycles = 0,0,1,1,2.
- Same parameters, four visible lines → line base addresses 0,0,3,3.
  - Last line reads addresses 3,3,4,4,5.
  - Output VISIBLE is high exactly 3 cycles after input VISIBLE.
- Default parameters, full 800×600 frame → final address of frame = 217727 (SRC_W·SRC_H−1). SX reaches 575 at pixel 799.
- MODE 1 with DOUT = 8'hE3 → R = 8'hFF, G = 8'h00, B = 8'hFF. MODE 3 with DOUT = 8'h12 → all channels 8'hED.
- VS asserted mid-line at DX=100 → next visible pixel reads address 0. Extra visible pixels beyond DST_W → RGB = 0 and BRAM_ADDR held.
- RESET pulsed mid-frame, or ENABLE low for one line → all outputs at reset values, or blank with delayed syncs. After VS the next frame starts at address 0.
